uart_tx_stim: RTL and testbench

- Synthesizable 8N1 UART transmitter for FPGA and simulation benches.
- Drives the SoC UART receive pin (RsRx) from a host-side byte stream: the opposite direction of the terminal receiver that watches RsTx.
- A small FIFO decouples byte writes from serial timing, so a bench or on-chip sequencer can queue characters back-to-back.
- Bit timing is a clock-count parameter. The default matches the 160 ns bit time at a 10 ns HCLK.

---
 rtl/uart_tx_stim.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_stim.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stim.sv
// uart_tx_stim: 8N1 UART transmitter with a small byte FIFO.
//
// Turns a host-side byte stream into serial frames on the SoC UART receive
// pin. Bytes are queued through a FIFO, so a sequencer can write characters
// back-to-back while the serialiser drains them at CLKS_PER_BIT cycles per bit.
//
// Ports:
//   HCLK     system clock, rising edge
//   HRESETn  asynchronous active-low reset
//   wdata    byte to queue
//   wr       write strobe, one byte per cycle while high
//   full     FIFO holds FIFO_DEPTH entries (registered)
//   empty    FIFO holds no entries (registered)
//   busy     frame in progress or FIFO non-empty (registered)
//   ovf      sticky overflow flag, set when a write is dropped
//   tx       serial line, idles high, driven from a register
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [7:0] wdata,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       tx
);

  localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [7:0]         shift, shift_nxt;
  logic               tx_nxt;
  logic               push, pop, wrap;

  // A write is taken only when the registered full flag is clear; a write
  // that coincides with a pop while full is still dropped.
  assign push = wr & ~full;
  assign wrap = (div == DIV_LAST);

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Serialiser next-state logic.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rptr];
          state_nxt = START;
        end
      end
      START: begin
        if (wrap) begin
          div_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      DATA: begin
        if (wrap) begin
          div_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      STOP: begin
        if (wrap) begin
          div_nxt = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx and busy are registered from the current state, so the line trails
  // the state register by one cycle: pop at N+1, start bit visible at N+2.
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift[0];
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      count   <= count_nxt;
      full    <= (count_nxt == CNT_FULL);
      empty   <= (count_nxt == '0);
      busy    <= (state != IDLE) | ~empty;
      tx      <= tx_nxt;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (wr && full) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
module tb_uart_tx_stim;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [7:0] wdata;
  logic       wr;
  logic       full, empty, busy, ovf, tx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] sb[$];
  int         starts[$];
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .wdata  (wdata),
    .wr     (wr),
    .full   (full),
    .empty  (empty),
    .busy   (busy),
    .ovf    (ovf),
    .tx     (tx)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Serial sampler: finds the start edge, samples mid-bit, pops the scoreboard.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          starts.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == CPB / 2) begin
          checks++;
          if (tx !== 1'b0) begin
            failures++;
            $display("FAIL start_bit_mid: got %b expected 0", tx);
          end
        end else if (mon_cnt >= CPB / 2 + CPB && mon_cnt < CPB / 2 + 9 * CPB &&
                     ((mon_cnt - CPB / 2) % CPB) == 0) begin
          mon_byte[(mon_cnt - CPB / 2) / CPB - 1] = tx;
        end else if (mon_cnt == CPB / 2 + 9 * CPB) begin
          checks++;
          if (tx !== 1'b1) begin
            failures++;
            $display("FAIL stop_bit_mid: got %b expected 1", tx);
          end
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame: got %h expected none", mon_byte);
          end else begin
            logic [7:0] exp_b;
            exp_b = sb.pop_front();
            if (mon_byte !== exp_b) begin
              failures++;
              $display("FAIL frame_byte: got %h expected %h", mon_byte, exp_b);
            end else begin
              $display("decoded byte %h '%c'", mon_byte, mon_byte);
            end
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic wait_drain(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (busy === 1'b0 && !mon_active && sb.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_start(input int n0, input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (starts.size() > n0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    wr      = 1'b0;
    wdata   = 8'h00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    sb.delete();
    starts.delete();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    wr      = 1'b0;
    wdata   = 8'h00;
    #1;
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if (tx !== 1'b1)    begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (full !== 1'b0)  begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single_55();
    int tn, tfall, tbusy, hi, n0;
    bit to;
    n0 = starts.size();
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'h55; sb.push_back(8'h55);
    @(posedge HCLK); #1;
    wr = 1'b0; tn = cyc;
    wait_start(n0, 10, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL single_start_seen: got none expected start edge");
      return;
    end
    tfall = starts[starts.size() - 1];
    checks++;
    if (tfall - tn !== 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", tfall - tn); end
    tbusy = -1; hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (cyc == tfall + 143) begin
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL single_bit7: got %b expected 0", tx); end
      end
      if (cyc >= tfall + 144 && cyc < tfall + 160 && tx === 1'b1) hi++;
      if (busy === 1'b0) begin tbusy = cyc; break; end
      step();
    end
    checks++;
    if (hi !== CPB) begin failures++; $display("FAIL single_stop_len: got %0d expected %0d", hi, CPB); end
    checks++;
    if (tbusy - tfall !== FRAME) begin
      failures++; $display("FAIL single_busy_fall: got %0d expected %0d", tbusy - tfall, FRAME);
    end
    wait_drain(100, to);
    checks++;
    if (to || sb.size() != 0) begin failures++; $display("FAIL single_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int n0;
    bit to;
    n0 = starts.size();
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'h41; sb.push_back(8'h41);
    @(posedge HCLK); #1;
    wdata = 8'h42; sb.push_back(8'h42);
    @(posedge HCLK); #1;
    wr = 1'b0;
    wait_drain(600, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_drain: got timeout expected idle"); end
    checks++;
    if (starts.size() !== n0 + 2) begin
      failures++; $display("FAIL b2b_frames: got %0d expected %0d", starts.size() - n0, 2);
    end else begin
      checks++;
      if (starts[n0 + 1] - starts[n0] !== FRAME) begin
        failures++; $display("FAIL b2b_spacing: got %0d expected %0d", starts[n0 + 1] - starts[n0], FRAME);
      end
    end
  endtask

  task automatic test_ff_00();
    int runs[$];
    int n0, len;
    logic cur;
    bit to;
    n0 = starts.size();
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'hFF; sb.push_back(8'hFF);
    @(posedge HCLK); #1;
    wdata = 8'h00; sb.push_back(8'h00);
    @(posedge HCLK); #1;
    wr = 1'b0;
    wait_start(n0, 10, to);
    checks++;
    if (to) begin failures++; $display("FAIL ff00_start_seen: got none expected start edge"); return; end
    cur = 1'b0; len = 1;
    for (int k = 1; k < 340; k++) begin
      step();
      if (tx === cur) len++;
      else begin runs.push_back(len); cur = tx; len = 1; end
    end
    runs.push_back(len);
    checks++;
    if (runs.size() !== 4) begin
      failures++; $display("FAIL ff00_run_count: got %0d expected 4", runs.size());
    end else begin
      checks++; if (runs[0] !== CPB)     begin failures++; $display("FAIL ff_start_low: got %0d expected %0d", runs[0], CPB); end
      checks++; if (runs[1] !== 9 * CPB) begin failures++; $display("FAIL ff_high_run: got %0d expected %0d", runs[1], 9 * CPB); end
      checks++; if (runs[2] !== 9 * CPB) begin failures++; $display("FAIL zero_low_run: got %0d expected %0d", runs[2], 9 * CPB); end
      checks++; if (runs[3] < CPB)       begin failures++; $display("FAIL zero_stop_run: got %0d expected >=%0d", runs[3], CPB); end
    end
    wait_drain(100, to);
    checks++;
    if (to || sb.size() != 0) begin failures++; $display("FAIL ff00_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_overflow();
    bit to;
    do_reset();
    @(posedge HCLK); #1;
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 8'h30 + i[7:0];
      if (i < 5) sb.push_back(8'h30 + i[7:0]);
      if (i == 5) begin
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full_before: got %b expected 1", full); end
        checks++; if (ovf !== 1'b0)  begin failures++; $display("FAIL ovf_clear_before: got %b expected 0", ovf); end
      end
      @(posedge HCLK); #1;
    end
    wr = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    wait_drain(1200, to);
    checks++;
    if (to || sb.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d left expected 0", sb.size()); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_reset_midframe();
    int n0, n1, tfall;
    bit to;
    do_reset();
    n0 = starts.size();
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'hA5;
    @(posedge HCLK); #1;
    wdata = 8'h11;
    @(posedge HCLK); #1;
    wdata = 8'h22;
    @(posedge HCLK); #1;
    wr = 1'b0;
    wait_start(n0, 10, to);
    checks++;
    if (to) begin failures++; $display("FAIL mid_start_seen: got none expected start edge"); return; end
    tfall = starts[starts.size() - 1];
    while (cyc < tfall + 70) step();
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_bit3: got %b expected 0", tx); end
    HRESETn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)    begin failures++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty: got %b expected 1", empty); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    n1 = starts.size();
    repeat (400) step();
    checks++; if (starts.size() !== n1) begin failures++; $display("FAIL mid_no_frames: got %0d expected 0", starts.size() - n1); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL mid_idle_busy: got %b expected 0", busy); end
    checks++; if (tx !== 1'b1)    begin failures++; $display("FAIL mid_idle_tx: got %b expected 1", tx); end
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'h5A; sb.push_back(8'h5A);
    @(posedge HCLK); #1;
    wr = 1'b0;
    wait_drain(400, to);
    checks++;
    if (to || sb.size() != 0) begin failures++; $display("FAIL mid_after_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_full_pop();
    int tn;
    bit to;
    do_reset();
    tn = 0;
    @(posedge HCLK); #1;
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'h61 + i[7:0];
      sb.push_back(8'h61 + i[7:0]);
      @(posedge HCLK); #1;
      if (i == 0) tn = cyc;
    end
    wr = 1'b0;
    while (cyc < tn + FRAME) begin
      @(posedge HCLK); #1;
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fp_full_before: got %b expected 1", full); end
    checks++; if (ovf !== 1'b0)  begin failures++; $display("FAIL fp_ovf_before: got %b expected 0", ovf); end
    wr = 1'b1; wdata = 8'h66;
    @(posedge HCLK); #1;
    wr = 1'b0;
    checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL fp_ovf_set: got %b expected 1", ovf); end
    checks++; if (full !== 1'b0)  begin failures++; $display("FAIL fp_count_dec: got full=%b expected 0", full); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fp_not_empty: got %b expected 0", empty); end
    wait_drain(1200, to);
    checks++;
    if (to || sb.size() != 0) begin failures++; $display("FAIL fp_drain: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_ff_00();
    test_overflow();
    test_reset_midframe();
    test_full_pop();
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
